// File: rtl/rf_pkg.sv
// Shared widths, writeback entry type and one-hot register decode for the RF write path.
package rf_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  vld;
        addr_t dest;
        data_t dat;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] dec(input addr_t addr);
        logic [NUM_REGS-1:0] onehot;
        onehot       = '0;
        onehot[addr] = 1'b1;
        return onehot;
    endfunction
endpackage

// File: rtl/rf_wb_slot.sv
// One-entry writeback holding register: valid/dest/data.
// Latency: loads on the accepting edge. Backpressure: owner drives load/clear; load wins over clear.
module rf_wb_slot
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  logic      clear,
    input  addr_t     load_dest,
    input  data_t     load_data,
    output wb_entry_t entry
);
    wb_entry_t entry_nxt;

    always_comb begin
        entry_nxt     = entry;
        entry_nxt.vld = entry.vld & ~clear;
        if (load) begin
            entry_nxt.vld  = 1'b1;
            entry_nxt.dest = load_dest;
            entry_nxt.dat  = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) entry <= '0;
        else       entry <= entry_nxt;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU (port 0) and load (port 1) writebacks onto the single DPRF write port, oldest first.
// Latency: accept at edge N -> rf_we high after edge N+1. Backpressure: reqN_ready = slot empty or draining.
module rf_write_arbiter
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [ADDR_W-1:0]   req0_dest,
    input  logic [DATA_W-1:0]   req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [ADDR_W-1:0]   req1_dest,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_regsel_dest,
    output logic [DATA_W-1:0]   rf_datain,
    output logic [NUM_REGS-1:0] pending_mask
);
    wb_entry_t slot0, slot1;
    logic      grant0, grant1;
    logic      acc0, acc1;
    logic      stay0, stay1;
    logic      tie_q, old_sel_q, rr_q;

    // tie_q marks that both current entries arrived on the same edge, so age is undefined and rr decides
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (slot0.vld && slot1.vld) begin
            if (tie_q ? rr_q : old_sel_q) grant1 = 1'b1;
            else                          grant0 = 1'b1;
        end else begin
            grant0 = slot0.vld;
            grant1 = slot1.vld;
        end
    end

    assign req0_ready = ~reset & (~slot0.vld | grant0);
    assign req1_ready = ~reset & (~slot1.vld | grant1);
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;
    assign stay0      = slot0.vld & ~grant0;
    assign stay1      = slot1.vld & ~grant1;

    rf_wb_slot u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .load      (acc0),
        .clear     (grant0),
        .load_dest (req0_dest),
        .load_data (req0_data),
        .entry     (slot0)
    );

    rf_wb_slot u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load      (acc1),
        .clear     (grant1),
        .load_dest (req1_dest),
        .load_data (req1_data),
        .entry     (slot1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tie_q     <= 1'b0;
            old_sel_q <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            tie_q     <= tie_q;
            old_sel_q <= old_sel_q;
            rr_q      <= (slot0.vld & slot1.vld & tie_q) ? ~rr_q : rr_q;
            if (acc0 && acc1) begin
                tie_q <= 1'b1;
            end else if (acc0 && stay1) begin
                tie_q     <= 1'b0;
                old_sel_q <= 1'b1;
            end else if (acc1 && stay0) begin
                tie_q     <= 1'b0;
                old_sel_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we          <= 1'b0;
            rf_regsel_dest <= '0;
            rf_datain      <= '0;
        end else begin
            rf_we          <= grant0 | grant1;
            rf_regsel_dest <= rf_regsel_dest;
            rf_datain      <= rf_datain;
            if (grant1) begin
                rf_regsel_dest <= slot1.dest;
                rf_datain      <= slot1.dat;
            end else if (grant0) begin
                rf_regsel_dest <= slot0.dest;
                rf_datain      <= slot0.dat;
            end
        end
    end

    assign pending_mask = (slot0.vld ? dec(slot0.dest)     : '0)
                        | (slot1.vld ? dec(slot1.dest)     : '0)
                        | (rf_we     ? dec(rf_regsel_dest) : '0);
endmodule
